// File: rtl/mdr_unit.sv
// Memory data register: bus load, memory read/write handshake with ack timeout,
// and a registered output that drives the bus only when oe is set.
module mdr_unit #(
  parameter int DW      = 18,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_bus,
  input  logic [DW-1:0] bus_in,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic          oe,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mdr_out,
  output logic          mdr_oe,
  output logic [DW-1:0] mdr_q,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // state | meaning
  // IDLE  | no transaction; accepts rd_req > wr_req > ld_bus
  // RD    | memory read outstanding; register loads on ack
  // WR    | memory write outstanding; register is held
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    cnt;
  logic [DW-1:0] mdr_reg;

  assign mdr_q     = mdr_reg;
  assign mem_wdata = mdr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      mdr_reg <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            state   <= RD;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            busy    <= 1'b1;
            cnt     <= 8'd0;
          end else if (wr_req) begin
            state   <= WR;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            busy    <= 1'b1;
            cnt     <= 8'd0;
          end else if (ld_bus) begin
            mdr_reg <= bus_in;
          end
        end
        RD, WR: begin
          if (mem_ack) begin
            if (state == RD) mdr_reg <= mem_rdata;
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            // Ack wins over timeout on the same edge since it is tested first.
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Output path runs every cycle regardless of state; reset forces it quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdr_out <= '0;
      mdr_oe  <= 1'b0;
    end else begin
      mdr_out <= oe ? mdr_reg : '0;
      mdr_oe  <= oe;
    end
  end

endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit with DW=18, TIMEOUT=4.
module tb_mdr_unit;

  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_bus;
  logic [DW-1:0] bus_in;
  logic          rd_req;
  logic          wr_req;
  logic          oe;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mdr_out;
  logic          mdr_oe;
  logic [DW-1:0] mdr_q;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;
  int n;

  mdr_unit #(.DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ld_bus(ld_bus), .bus_in(bus_in),
    .rd_req(rd_req), .wr_req(wr_req), .oe(oe),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mdr_out(mdr_out), .mdr_oe(mdr_oe), .mdr_q(mdr_q),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    ld_bus = 1'($urandom); bus_in = DW'($urandom); rd_req = 1'($urandom);
    wr_req = 1'($urandom); oe = 1'b1; mem_rdata = DW'($urandom); mem_ack = 1'($urandom);
    step();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mdr_q", 32'(mdr_q), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_mdr_out", 32'(mdr_out), 0);
    chk("rst_mdr_oe", 32'(mdr_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    rst = 0; ld_bus = 0; bus_in = 0; rd_req = 0; wr_req = 0; oe = 0;
    mem_rdata = 0; mem_ack = 0;
    step();

    // Bus load then oe
    ld_bus = 1; bus_in = 18'h2A5A5;
    step();
    ld_bus = 0;
    chk("ld_mdr_q", 32'(mdr_q), 32'h2A5A5);
    chk("ld_mdr_oe_off", 32'(mdr_oe), 0);
    oe = 1;
    step();
    chk("oe_mdr_out", 32'(mdr_out), 32'h2A5A5);
    chk("oe_mdr_oe", 32'(mdr_oe), 1);
    oe = 0;
    step();
    chk("oe_off_mdr_out", 32'(mdr_out), 0);
    chk("oe_off_mdr_oe", 32'(mdr_oe), 0);

    // Read with 2 wait states
    rd_req = 1;
    step();
    rd_req = 0;
    chk("rd_req_c1", 32'(mem_req), 1);
    chk("rd_we", 32'(mem_we), 0);
    chk("rd_busy", 32'(busy), 1);
    step();
    chk("rd_req_c2", 32'(mem_req), 1);
    step();
    chk("rd_req_c3", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 18'h3FFFF;
    step();
    mem_ack = 0; mem_rdata = 0;
    chk("rd_req_drop", 32'(mem_req), 0);
    chk("rd_done", 32'(done), 1);
    chk("rd_busy_drop", 32'(busy), 0);
    chk("rd_mdr_q", 32'(mdr_q), 32'h3FFFF);
    step();
    chk("rd_done_pulse", 32'(done), 0);

    // Write with zero wait states
    ld_bus = 1; bus_in = 18'h00123;
    step();
    ld_bus = 0; wr_req = 1;
    step();
    wr_req = 0;
    chk("wr_req_c1", 32'(mem_req), 1);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_wdata", 32'(mem_wdata), 32'h00123);
    mem_ack = 1; mem_rdata = 18'h3AAAA;
    step();
    mem_ack = 0;
    chk("wr_req_drop", 32'(mem_req), 0);
    chk("wr_done", 32'(done), 1);
    chk("wr_mdr_q", 32'(mdr_q), 32'h00123);

    // ack in IDLE is ignored
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("idle_ack_done", 32'(done), 0);
    chk("idle_ack_q", 32'(mdr_q), 32'h00123);

    // Timeout without ack
    rd_req = 1;
    step();
    rd_req = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 4);
    chk("to_err", 32'(err), 1);
    chk("to_done", 32'(done), 0);
    chk("to_mdr_q", 32'(mdr_q), 32'h00123);
    step();
    chk("to_err_pulse", 32'(err), 0);

    // Ack on the timeout cycle
    rd_req = 1;
    step();
    rd_req = 0;
    step();
    step();
    step();
    chk("ackto_req_c4", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 18'h15555;
    step();
    mem_ack = 0;
    chk("ackto_done", 32'(done), 1);
    chk("ackto_err", 32'(err), 0);
    chk("ackto_mdr_q", 32'(mdr_q), 32'h15555);
    step();

    // Priority: all three requests together -> read only
    rd_req = 1; wr_req = 1; ld_bus = 1; bus_in = 18'h0F0F0;
    step();
    rd_req = 0; wr_req = 0; ld_bus = 0;
    chk("pri_we", 32'(mem_we), 0);
    chk("pri_busy", 32'(busy), 1);
    chk("pri_mdr_q", 32'(mdr_q), 32'h15555);
    ld_bus = 1; bus_in = 18'h11111;
    step();
    ld_bus = 0;
    chk("busy_ld_ignored", 32'(mdr_q), 32'h15555);
    mem_ack = 1; mem_rdata = 18'h22222;
    step();
    mem_ack = 0;
    chk("pri_done", 32'(done), 1);
    chk("pri_rd_q", 32'(mdr_q), 32'h22222);
    step();

    // Reset during WR
    wr_req = 1;
    step();
    wr_req = 0;
    chk("mrst_req_on", 32'(mem_req), 1);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_req", 32'(mem_req), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_err", 32'(err), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_no_err", 32'(err), 0);
      chk("mrst_no_done", 32'(done), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdr_unit.md
# mdr_unit

Parametrised memory data register with a memory-side request/acknowledge handshake, ack timeout, and a registered, enable-qualified bus output. It replaces the fixed 18-bit, single-cycle data register between the processor bus and data memory. It adds:
- memory read and write transactions with wait-state tolerance,
- completion and error pulses,
- a defined output-enable flag instead of driving high-impedance from a flop.

## Interface
- DW, default 18: data width of the register, bus and memory data.
- TIMEOUT, default 15: maximum cycles `mem_req` stays high waiting for `mem_ack`; legal range 1..255.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- ld_bus  in  1  load the register from `bus_in`; accepted only in IDLE.
- bus_in  in  DW  bus write data.
- rd_req  in  1  start a memory read into the register; accepted only in IDLE.
- wr_req  in  1  start a memory write of the register; accepted only in IDLE.
- oe  in  1  present the register on `mdr_out`.
- mem_rdata  in  DW  memory read data; valid when `mem_ack`=1 during a read.
- mem_ack  in  1  memory completion strobe.
- mem_req  out  1  memory request; registered.
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- mem_wdata  out  DW  write data; equals the register contents.
- mdr_out  out  DW  registered bus output; 0 when not enabled.
- mdr_oe  out  1  `mdr_out` is valid and is to be driven onto the bus.
- mdr_q  out  DW  direct register contents, for debug and datapath.
- busy  out  1  FSM is not in IDLE.
- done  out  1  one-cycle pulse when a transaction completes with ack.
- err  out  1  one-cycle pulse when a transaction times out.

## Operation
- **State machine:** IDLE, RD, WR; 2-bit encoding.
- **IDLE, request priority:** `rd_req` > `wr_req` > `ld_bus`. Only the highest-priority asserted request is taken; the others are dropped and not queued.
  - `rd_req`: go to RD; `mem_req`<=1, `mem_we`<=0, `cnt`<=0.
  - `wr_req`: go to WR; `mem_req`<=1, `mem_we`<=1, `cnt`<=0.
  - `ld_bus`: register <= `bus_in`; stay in IDLE.
- **RD:**
  - `mem_ack`=1: register <= `mem_rdata`, `mem_req`<=0, `done`<=1, go to IDLE.
  - Else if `cnt`==TIMEOUT-1: `mem_req`<=0, `err`<=1, register unchanged, go to IDLE.
  - Else `cnt`<=`cnt`+1.
- **WR:** same as RD, except the register is never modified. `mem_wdata` holds steady for the whole transaction.
- **Ignored while busy:** `ld_bus`, `rd_req` and `wr_req` in RD/WR have no effect.
- **mem_ack outside RD/WR:** ignored.
- **Output path:** independent of the FSM. Each cycle, `mdr_out` <= (`oe` ? register : 0) and `mdr_oe` <= `oe`. `oe` is honoured in every state.
- **Counter:** `cnt` is an 8-bit unsigned value; it never wraps, because the timeout fires first.

## Timing
- **Reset:** the register, `mdr_out`, `mem_wdata` and `mdr_q` are 0. `mdr_oe`, `mem_req`, `mem_we`, `busy`, `done` and `err` are 0. State is IDLE and `cnt`=0.
- **Reset mid-transaction:** abort on the same edge. `mem_req` is 0 the next cycle, and no `done`/`err` is issued.
- **ld_bus latency:** `ld_bus` sampled at edge N updates `mdr_q` after N. With `oe` at edge N+1, `mdr_out` shows the new value after N+1.
- **oe latency:** `oe` at edge N gives `mdr_out`/`mdr_oe` valid after N. Both drop one cycle after `oe` drops.
- **Request issue:** a request sampled at edge N gives `mem_req`=1 and `busy`=1 after N.
- **Ack:** `mem_ack` sampled at edge M completes the transaction. After M: `mem_req`=0, `done`=1 for one cycle, `busy`=0, and for a read `mdr_q`=`mem_rdata`. A new request is accepted at edge M+1.
- **Zero wait states:** `mem_ack` at the first edge after `mem_req` rises gives `mem_req` high for exactly 1 cycle.
- **Timeout:** with no ack, `mem_req` stays high exactly TIMEOUT cycles, then `err`=1 for one cycle.
- **Ack on the timeout edge:** ack wins; `done`=1, `err`=0.

## Test plan
All scenarios use DW=18, TIMEOUT=4.
- **Reset:** assert `rst` with all inputs random -> every output 0 on the next cycle.
- **Bus load:** `ld_bus`, `bus_in`=0x2A5A5, then `oe` -> `mdr_q`=0x2A5A5 one cycle later; `mdr_out`=0x2A5A5 and `mdr_oe`=1 the cycle after `oe`; `mdr_out`=0 after `oe` drops.
- **Read with 2 wait states:** `rd_req`, then `mem_ack` with `mem_rdata`=0x3FFFF on the 3rd `mem_req` cycle -> `mem_req` high 3 cycles, `mem_we`=0, `done` pulse, `mdr_q`=0x3FFFF.
- **Write, zero wait:** `mdr_q`=0x00123, `wr_req`, ack next cycle -> `mem_req` high 1 cycle, `mem_we`=1, `mem_wdata`=0x00123, `done` pulse, register unchanged.
- **Timeout and ack-at-timeout:**
  - No ack -> `mem_req` high 4 cycles, `err` pulse, register unchanged.
  - Repeat with ack on the 4th cycle -> `done`=1, `err`=0.
- **Priority, busy and mid-reset:**
  - `rd_req`+`wr_req`+`ld_bus` together -> read only.
  - `ld_bus` during RD -> register unchanged.
  - `rst` during WR -> `mem_req`=0 next cycle, no `done`/`err`.
